// File: rtl/frog_hop_ctrl_pkg.sv
// Shared frog types: facing direction (also used by the renderer for sprite facing),
// hop-controller state and the request priority encoder.
package frogger_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;
  typedef enum logic {ST_IDLE, ST_HOP} state_t;

  // Simultaneous pulses resolve forward > backward > right > left.
  function automatic dir_t pick_dir(input logic fwd, input logic bwd,
                                    input logic rgt, input logic lft);
    if (fwd) return DIR_UP;
    if (bwd) return DIR_DOWN;
    if (rgt) return DIR_RIGHT;
    if (lft) return DIR_LEFT;
    return DIR_UP;
  endfunction

endpackage

// File: rtl/frog_hop_ctrl_if.sv
// Move-request / hop-status bundle between the input conditioner side (master)
// and the frog hop controller (slave).
interface frog_hop_ctrl_if #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 13
);
    import frogger_pkg::*;

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    logic          forward_pulse;
    logic          backward_pulse;
    logic          right_pulse;
    logic          left_pulse;
    logic          freeze;
    logic          respawn;
    logic [XW-1:0] frog_x;
    logic [YW-1:0] frog_y;
    dir_t          hop_dir;
    logic          hopping;
    logic          hop_done;
    logic          blocked;

    modport master (
        output forward_pulse, backward_pulse, right_pulse, left_pulse, freeze, respawn,
        input  frog_x, frog_y, hop_dir, hopping, hop_done, blocked
    );

    modport slave (
        input  forward_pulse, backward_pulse, right_pulse, left_pulse, freeze, respawn,
        output frog_x, frog_y, hop_dir, hopping, hop_done, blocked
    );

endinterface

// File: rtl/frog_hop_ctrl.sv
// Frog hop controller: turns move pulses into paced, edge-clamped grid hops.
// Optional feature: define HOP_QUEUE_EN for a one-entry request buffer during hops.
module frog_hop_ctrl
    import frogger_pkg::*;
#(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 13,
    parameter int START_X    = 7,
    parameter int START_Y    = 12,
    parameter int HOP_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    frog_hop_ctrl_if.slave bus
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int CW = $clog2(HOP_CYCLES);

    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW:0]   X_LAST  = (XW+1)'(GRID_W - 1);
    localparam logic [YW:0]   Y_LAST  = (YW+1)'(GRID_H - 1);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [CW-1:0] C_LAST  = CW'(HOP_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic          rst_meta;
    logic          rst_sync_n;
    state_t        state;
    logic [CW-1:0] hop_cnt;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    dir_t          face_dir;
    logic          hopping;
    logic          hop_done;
    logic          blocked;
`ifdef HOP_QUEUE_EN
    logic          buf_vld;
    dir_t          buf_dir;
`endif

    logic          live_vld;
    dir_t          live_dir;
    logic          sel_vld;
    dir_t          sel_dir;
    logic          in_bounds;
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;

    // Reset asserts asynchronously but is released in step with clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    assign live_vld = !bus.freeze &&
                      (bus.forward_pulse || bus.backward_pulse ||
                       bus.right_pulse   || bus.left_pulse);
    assign live_dir = pick_dir(bus.forward_pulse, bus.backward_pulse,
                               bus.right_pulse, bus.left_pulse);

    // The request to act on now: live in IDLE, buffered-or-live on the last hop cycle.
    always_comb begin
        sel_vld = 1'b0;
        sel_dir = live_dir;
        if (state == ST_IDLE) begin
            sel_vld = live_vld;
        end
`ifdef HOP_QUEUE_EN
        else if (hop_cnt == '0) begin
            sel_vld = buf_vld || live_vld;
            sel_dir = buf_vld ? buf_dir : live_dir;
        end
`endif
    end

    // Bound check on one-bit-wider values so a step past the edge can never wrap.
    always_comb begin
        in_bounds = 1'b0;
        tgt_x     = pos_x;
        tgt_y     = pos_y;
        case (sel_dir)
            DIR_UP: begin
                in_bounds = (pos_y != '0);
                tgt_y     = pos_y - Y_ONE;
            end
            DIR_DOWN: begin
                in_bounds = ({1'b0, pos_y} < Y_LAST);
                tgt_y     = pos_y + Y_ONE;
            end
            DIR_RIGHT: begin
                in_bounds = ({1'b0, pos_x} < X_LAST);
                tgt_x     = pos_x + X_ONE;
            end
            default: begin
                in_bounds = (pos_x != '0);
                tgt_x     = pos_x - X_ONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state    <= ST_IDLE;
            hop_cnt  <= '0;
            pos_x    <= X_START;
            pos_y    <= Y_START;
            face_dir <= DIR_UP;
            hopping  <= 1'b0;
            hop_done <= 1'b0;
            blocked  <= 1'b0;
`ifdef HOP_QUEUE_EN
            buf_vld  <= 1'b0;
            buf_dir  <= DIR_UP;
`endif
        end else if (bus.respawn) begin
            state    <= ST_IDLE;
            hop_cnt  <= '0;
            pos_x    <= X_START;
            pos_y    <= Y_START;
            face_dir <= DIR_UP;
            hopping  <= 1'b0;
            hop_done <= 1'b0;
            blocked  <= 1'b0;
`ifdef HOP_QUEUE_EN
            buf_vld  <= 1'b0;
`endif
        end else begin
            hop_done <= 1'b0;
            blocked  <= 1'b0;
            if (state == ST_HOP && hop_cnt != '0) begin
                hop_cnt  <= hop_cnt - C_ONE;
                hop_done <= (hop_cnt == C_ONE);
`ifdef HOP_QUEUE_EN
                if (live_vld && !buf_vld) begin
                    buf_vld <= 1'b1;
                    buf_dir <= live_dir;
                end
`endif
            end else begin
                // IDLE, or the final hop cycle: settle, then act on any selected request.
                state   <= ST_IDLE;
                hopping <= 1'b0;
`ifdef HOP_QUEUE_EN
                buf_vld <= 1'b0;
`endif
                if (sel_vld) begin
                    face_dir <= sel_dir;
                    if (in_bounds) begin
                        pos_x   <= tgt_x;
                        pos_y   <= tgt_y;
                        state   <= ST_HOP;
                        hopping <= 1'b1;
                        hop_cnt <= C_LAST;
                    end else begin
                        blocked <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.frog_x   = pos_x;
    assign bus.frog_y   = pos_y;
    assign bus.hop_dir  = face_dir;
    assign bus.hopping  = hopping;
    assign bus.hop_done = hop_done;
    assign bus.blocked  = blocked;

endmodule
